// File: rtl/sstl18_dci_hdx_link.sv
// Half-duplex single-wire link controller for an SSTL18 DCI bidirectional pad.
// Sends a framed request, releases the line, receives a framed response, then guards the line.
module sstl18_dci_hdx_link #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TURN  = 2,
  parameter int unsigned TMO   = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic             busy,
  output logic             pad_i,
  output logic             pad_t,
  input  logic             pad_o
);

  // Wide enough for WIDTH+1, TURN-1 and TMO-1 at their maxima.
  localparam int unsigned CW = 11;

  typedef enum logic [2:0] {StIdle, StDrive, StTurn, StWait, StRecv, StGuard} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tsh_q, tsh_d;
  logic [WIDTH-1:0] rsh_q, rsh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic             pad_i_q, pad_i_d;
  logic             pad_t_q;
  logic             tx_ready_q;
  logic             busy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tsh_d      = tsh_q;
    rsh_d      = rsh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    pad_i_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (tx_valid && tx_ready_q) begin
          tsh_d   = tx_data;
          cnt_d   = '0;
          pad_i_d = 1'b0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        // cnt 0..WIDTH-1 emits data MSB first, cnt WIDTH emits stop, cnt WIDTH+1 releases.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q < CW'(WIDTH)) begin
          pad_i_d = tsh_q[WIDTH-1];
          tsh_d   = tsh_q << 1;
        end else if (cnt_q == CW'(WIDTH + 1)) begin
          cnt_d   = '0;
          state_d = StTurn;
        end
      end
      StTurn: begin
        if (cnt_q == CW'(TURN - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWait: begin
        // A start bit on the last allowed sample still wins over the timeout.
        if (!pad_o) begin
          cnt_d   = '0;
          state_d = StRecv;
        end else if (cnt_q == CW'(TMO - 1)) begin
          cnt_d    = '0;
          rx_err_d = 1'b1;
          state_d  = StGuard;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StRecv: begin
        if (cnt_q == CW'(WIDTH)) begin
          rx_data_d  = rsh_q;
          rx_valid_d = pad_o;
          rx_err_d   = !pad_o;
          cnt_d      = '0;
          state_d    = StGuard;
        end else begin
          rsh_d = WIDTH'({rsh_q, pad_o});
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGuard: begin
        if (cnt_q == CW'(TURN - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tsh_q      <= '0;
      rsh_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      pad_i_q    <= 1'b1;
      pad_t_q    <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tsh_q      <= tsh_d;
      rsh_q      <= rsh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      pad_i_q    <= pad_i_d;
      pad_t_q    <= (state_d != StDrive);
      tx_ready_q <= (state_d == StIdle);
      busy_q     <= (state_d != StIdle);
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = busy_q;
  assign pad_i    = pad_i_q;
  assign pad_t    = pad_t_q;

endmodule

// File: tb/tb_sstl18_dci_hdx_link.sv
// Directed bench for sstl18_dci_hdx_link: table of framed transactions plus
// hand-written reset-during-receive and back-to-back request sequences.
module tb_sstl18_dci_hdx_link;

  localparam int W  = 8;
  localparam int T  = 2;
  localparam int TM = 64;

  logic         clk;
  logic         rstn;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_err;
  logic         busy;
  logic         pad_i;
  logic         pad_t;
  logic         pad_o;

  sstl18_dci_hdx_link #(
    .WIDTH(W),
    .TURN (T),
    .TMO  (TM)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy),
    .pad_i   (pad_i),
    .pad_t   (pad_t),
    .pad_o   (pad_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [9:0] line;
    logic [7:0] resp;
    logic       stop;
    logic       respond;
    int         delay;
    logic       pre;
    logic       exp_v;
    logic       exp_e;
    logic [7:0] exp_d;
  } vec_t;

  int   n_cmp;
  int   n_fail;
  int   vcnt;
  int   ecnt;
  int   bad;
  int   ovl;
  int   acc;
  logic prev_v;
  logic prev_e;
  logic bench_drv;

  // Pulse, exclusivity, line-contention and accept monitor, sampled mid-cycle.
  initial begin
    prev_v = 1'b0;
    prev_e = 1'b0;
  end
  always @(negedge clk) begin
    if (rx_valid === 1'b1) vcnt++;
    if (rx_err === 1'b1) ecnt++;
    if (rx_valid === 1'b1 && rx_err === 1'b1) bad++;
    if ((rx_valid === 1'b1 && prev_v) || (rx_err === 1'b1 && prev_e)) bad++;
    prev_v = (rx_valid === 1'b1);
    prev_e = (rx_err === 1'b1);
    if (bench_drv && pad_t !== 1'b1) ovl++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) acc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("ready_wait", {31'b0, tx_ready}, 32'd1);
  endtask

  // Runs from just after the accept edge through the guard window.
  task automatic serve(input vec_t v);
    logic [9:0] line;
    logic       drv_ok, turn_ok, quiet_ok, guard_ok;
    int         v0, e0;
    v0     = vcnt;
    e0     = ecnt;
    pad_o  = v.pre;
    line   = '0;
    drv_ok = 1'b1;
    check("busy", {31'b0, busy}, 32'd1);
    for (int j = 0; j < W + 2; j++) begin
      if (j > 0) tick();
      line = {line[8:0], pad_i};
      if (pad_t !== 1'b0) drv_ok = 1'b0;
    end
    check("line", {22'b0, line}, {22'b0, v.line});
    check("drive_t", {31'b0, drv_ok}, 32'd1);
    turn_ok = 1'b1;
    for (int j = 0; j < T + 1; j++) begin
      tick();
      if (pad_t !== 1'b1 || pad_i !== 1'b1) turn_ok = 1'b0;
    end
    check("turn_release", {31'b0, turn_ok}, 32'd1);
    quiet_ok = 1'b1;
    if (v.respond) begin
      for (int j = 0; j < v.delay; j++) begin
        pad_o = 1'b1;
        tick();
        if (rx_valid !== 1'b0 || rx_err !== 1'b0) quiet_ok = 1'b0;
      end
      pad_o     = 1'b0;
      bench_drv = 1'b1;
      tick();
      for (int k = 0; k < W; k++) begin
        pad_o = v.resp[W-1-k];
        tick();
      end
      pad_o = v.stop;
      tick();
      pad_o     = 1'b1;
      bench_drv = 1'b0;
    end else begin
      pad_o = 1'b1;
      for (int j = 0; j < TM - 1; j++) begin
        tick();
        if (rx_valid !== 1'b0 || rx_err !== 1'b0) quiet_ok = 1'b0;
      end
      tick();
    end
    check("quiet_before", {31'b0, quiet_ok}, 32'd1);
    check("rx_valid", {31'b0, rx_valid}, {31'b0, v.exp_v});
    check("rx_err", {31'b0, rx_err}, {31'b0, v.exp_e});
    check("rx_data", {24'b0, rx_data}, {24'b0, v.exp_d});
    guard_ok = 1'b1;
    for (int g = 1; g < T; g++) begin
      tick();
      if (tx_ready !== 1'b0 || pad_t !== 1'b1 || rx_valid !== 1'b0 || rx_err !== 1'b0)
        guard_ok = 1'b0;
    end
    check("guard", {31'b0, guard_ok}, 32'd1);
    tick();
    check("ready_back", {31'b0, tx_ready}, 32'd1);
    check("valid_count", vcnt - v0, {31'b0, v.exp_v});
    check("err_count", ecnt - e0, {31'b0, v.exp_e});
  endtask

  task automatic do_txn(input vec_t v);
    wait_ready();
    tx_data  = v.tx;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~v.tx;
    serve(v);
  endtask

  vec_t       vecs[6];
  vec_t       hv;
  logic [7:0] hw[3];
  logic [9:0] hl[3];
  logic [7:0] hr[3];
  int         v0, e0, a0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_fail = 0; vcnt = 0; ecnt = 0; bad = 0; ovl = 0; acc = 0;
    bench_drv = 1'b0;
    //           tx     line            resp   stop resp delay pre  v     e     data
    vecs[0] = '{8'hA5, 10'b0101001011, 8'h3C, 1'b1, 1'b1, 0,  1'b1, 1'b1, 1'b0, 8'h3C};
    vecs[1] = '{8'h00, 10'b0000000001, 8'hFF, 1'b0, 1'b1, 3,  1'b1, 1'b0, 1'b1, 8'hFF};
    vecs[2] = '{8'hFF, 10'b0111111111, 8'h81, 1'b1, 1'b1, 5,  1'b1, 1'b1, 1'b0, 8'h81};
    vecs[3] = '{8'h5A, 10'b0010110101, 8'h00, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b1, 8'h81};
    vecs[4] = '{8'h3C, 10'b0001111001, 8'hC3, 1'b1, 1'b1, 0,  1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[5] = '{8'h01, 10'b0000000011, 8'h80, 1'b1, 1'b1, 63, 1'b1, 1'b1, 1'b0, 8'h80};

    rstn     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    pad_o    = 1'b1;
    repeat (3) tick();
    check("rst_pad_t", {31'b0, pad_t}, 32'd1);
    check("rst_pad_i", {31'b0, pad_i}, 32'd1);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_err", {31'b0, rx_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    rstn = 1'b1;
    tick();
    check("ready_after_rst", {31'b0, tx_ready}, 32'd1);

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Reset asserted for one cycle two bits into a response.
    wait_ready();
    tx_data  = 8'hC7;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    pad_o    = 1'b1;
    repeat (W + 2 + T) tick();
    pad_o     = 1'b0;
    bench_drv = 1'b1;
    tick();
    pad_o = 1'b1;
    tick();
    pad_o = 1'b0;
    tick();
    check("busy_in_recv", {31'b0, busy}, 32'd1);
    v0   = vcnt;
    e0   = ecnt;
    rstn = 1'b0;
    tick();
    check("mid_pad_t", {31'b0, pad_t}, 32'd1);
    check("mid_pad_i", {31'b0, pad_i}, 32'd1);
    check("mid_tx_ready", {31'b0, tx_ready}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_rx_data", {24'b0, rx_data}, 32'd0);
    check("mid_rx_pulse", {30'b0, rx_valid, rx_err}, 32'd0);
    rstn      = 1'b1;
    bench_drv = 1'b0;
    pad_o     = 1'b1;
    repeat (2 * W + 8) tick();
    check("mid_no_pulse", (vcnt - v0) + (ecnt - e0), 32'd0);
    check("mid_ready", {31'b0, tx_ready}, 32'd1);
    hv = '{8'h96, 10'b0100101101, 8'h5A, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 8'h5A};
    do_txn(hv);

    // Three requests with tx_valid held high throughout.
    hw = '{8'h11, 8'h22, 8'h33};
    hl = '{10'b0000100011, 10'b0001000101, 10'b0001100111};
    hr = '{8'h44, 8'h55, 8'h66};
    a0 = acc;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = hw[i];
      wait_ready();
      tick();
      if (i == 2) tx_valid = 1'b0;
      tx_data = ~hw[i];
      hv = '{hw[i], hl[i], hr[i], 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, hr[i]};
      serve(hv);
    end
    repeat (5) tick();
    check("accepts", acc - a0, 32'd3);
    check("overlap", ovl, 32'd0);
    check("pulse_shape", bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
